phy_rx_deserializer: RTL

Receive-side serial-to-parallel converter for the PHY link. It samples the serial stream produced by the transmit PHY one bit per `clk_32f` edge, MSB first. It finds word alignment from the 0xBC comma/idle symbol, locks after a run of consecutive commas, and then presents each received byte as a registered parallel word with a valid flag. It sits between the serial link and the receive-side lane demux.

---
 rtl/phy_rx_deserializer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/phy_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module : phy_rx_deserializer
// Receive-side serial-to-parallel converter with 0xBC comma alignment and lock.
// Rev    : 1.0
// ============================================================================
module phy_rx_deserializer #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       word_strobe,
  output logic       active
);

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  // Only seven history bits are kept: the oldest bit of the byte register
  // never reaches the comparison window.
  logic [6:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;
  logic       active_q, active_d;

  logic [7:0] w;
  logic       word_end;
  logic       is_comma;

  always_comb begin
    w           = {sr_q, data_in};
    word_end    = (bit_cnt_q == 3'd7);
    is_comma    = (w == COMMA);
    sr_d        = w[6:0];
    bit_cnt_d   = bit_cnt_q + 3'd1;
    comma_cnt_d = comma_cnt_q;
    state_d     = state_q;
    data_d      = data_q;
    valid_d     = valid_q;
    strobe_d    = 1'b0;

    case (state_q)
      HUNT: begin
        if (is_comma) begin
          bit_cnt_d   = 3'd0;
          comma_cnt_d = 4'd1;
          if (LOCK_CNT == 4'd1) begin
            state_d  = ACTIVE;
            strobe_d = 1'b1;
          end else begin
            state_d = SYNC;
          end
        end
      end
      SYNC: begin
        if (word_end) begin
          if (is_comma) begin
            comma_cnt_d = (comma_cnt_q >= LOCK_CNT) ? LOCK_CNT : comma_cnt_q + 4'd1;
            if (comma_cnt_d == LOCK_CNT) begin
              state_d  = ACTIVE;
              strobe_d = 1'b1;
            end
          end else begin
            comma_cnt_d = 4'd0;
            state_d     = HUNT;
          end
        end
      end
      ACTIVE: begin
        if (word_end) begin
          strobe_d = 1'b1;
          if (is_comma) begin
            data_d  = 8'h00;
            valid_d = 1'b0;
          end else begin
            data_d  = w;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase

    active_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= HUNT;
      sr_q        <= 7'd0;
      bit_cnt_q   <= 3'd0;
      comma_cnt_q <= 4'd0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      strobe_q    <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      strobe_q    <= strobe_d;
      active_q    <= active_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign word_strobe = strobe_q;
  assign active      = active_q;

endmodule
`default_nettype wire
